// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one pipelined single-port memory between fetch and data ports, with return routing by tag
module unified_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int LAT = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_GNT,
    output logic          I_VALID,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [3:0]    D_BE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_VALID,
    output logic [DW-1:0] D_RDATA,
    input  logic          FLUSH,
    output logic          M_CSN,
    output logic          M_WEN,
    output logic [3:0]    M_BE,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_DOUT,
    input  logic [DW-1:0] M_DIN
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
    logic [LAT-1:0] vld_q, vld_d, own_q, own_d;
    logic i_win, st_gnt;
    always_comb begin
        i_win = I_REQ && (!D_REQ || starve_q == SMAX);
        I_GNT = !RST && !FLUSH && i_win;
        D_GNT = !RST && D_REQ && !I_GNT;
        st_gnt = D_GNT && D_WE;
        M_CSN = !(I_GNT || D_GNT);
        M_WEN = !st_gnt;
        M_BE = st_gnt ? D_BE : (M_CSN ? 4'h0 : 4'hf);
        M_ADDR = I_GNT ? I_ADDR : (D_GNT ? D_ADDR : '0);
        M_DOUT = st_gnt ? D_WDATA : '0;
        starve_d = (I_REQ && !I_GNT && !FLUSH) ? ((starve_q == SMAX) ? SMAX : starve_q + 4'd1) : 4'd0;
        vld_d = '0;
        own_d = '0;
        vld_d[0] = I_GNT || (D_GNT && !D_WE);
        own_d[0] = D_GNT;
        for (int k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1] && !(FLUSH && !own_q[k-1]);
            own_d[k] = own_q[k-1];
        end
        I_VALID = !RST && !FLUSH && vld_q[LAT-1] && !own_q[LAT-1];
        D_VALID = !RST && vld_q[LAT-1] && own_q[LAT-1];
        I_RDATA = I_VALID ? M_DIN : '0;
        D_RDATA = D_VALID ? M_DIN : '0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= 4'd0;
            vld_q <= '0;
            own_q <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed stimulus with a return-data scoreboard for unified_mem_arbiter
module tb_unified_mem_arbiter;
    logic        CLK = 0, RST;
    logic        I_REQ, I_GNT, I_VALID;
    logic [11:0] I_ADDR;
    logic [31:0] I_RDATA;
    logic        D_REQ, D_WE, D_GNT, D_VALID;
    logic [3:0]  D_BE;
    logic [11:0] D_ADDR;
    logic [31:0] D_WDATA, D_RDATA;
    logic        FLUSH, M_CSN, M_WEN;
    logic [3:0]  M_BE;
    logic [11:0] M_ADDR;
    logic [31:0] M_DOUT, M_DIN;
    logic [31:0] p0, p1;
    logic [31:0] iq[$], dq[$];
    int vectors = 0, miscompares = 0;

    unified_mem_arbiter #(.AW(12), .DW(32), .LAT(2), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA), .FLUSH(FLUSH),
        .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_DOUT(M_DOUT), .M_DIN(M_DIN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        p0 <= !M_CSN ? 32'(M_ADDR) + 32'h100 : 32'hBAD0_BAD0;
        p1 <= p0;
    end
    assign M_DIN = p1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (I_VALID) begin
            if (iq.size() == 0) chk("i_valid_unexpected", 32'(I_VALID), 32'd0);
            else chk("i_rdata", I_RDATA, iq.pop_front());
        end
        if (D_VALID) begin
            if (dq.size() == 0) chk("d_valid_unexpected", 32'(D_VALID), 32'd0);
            else chk("d_rdata", D_RDATA, dq.pop_front());
        end
    end

    initial begin
        RST = 1; FLUSH = 0;
        I_REQ = 1; I_ADDR = 12'h005;
        D_REQ = 1; D_WE = 0; D_BE = 4'h0; D_ADDR = 12'h007; D_WDATA = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("rst_i_gnt", 32'(I_GNT), 32'd0);
            chk("rst_d_gnt", 32'(D_GNT), 32'd0);
            chk("rst_m_csn", 32'(M_CSN), 32'd1);
            next();
        end
        RST = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk("starve_i_gnt", 32'(I_GNT), (c == 4) ? 32'd1 : 32'd0);
            chk("starve_d_gnt", 32'(D_GNT), (c == 4) ? 32'd0 : 32'd1);
            chk("starve_m_addr", 32'(M_ADDR), (c == 4) ? 32'h005 : 32'h007);
            if (c == 4) iq.push_back(32'h105);
            else dq.push_back(32'h107);
            next();
        end
        I_REQ = 0; D_REQ = 0;
        repeat (3) next();

        for (int c = 0; c < 3; c++) begin
            I_REQ = 1; I_ADDR = 12'h010 + 12'(c);
            @(negedge CLK);
            chk("pipe_i_gnt", 32'(I_GNT), 32'd1);
            chk("pipe_m_addr", 32'(M_ADDR), 32'h010 + 32'(c));
            if (c == 2) chk("pipe_i_valid_c2", 32'(I_VALID), 32'd1);
            iq.push_back(32'h110 + 32'(c));
            next();
        end
        I_REQ = 0;
        @(negedge CLK);
        chk("pipe_i_valid_c3", 32'(I_VALID), 32'd1);
        repeat (3) next();

        D_REQ = 1; D_WE = 1; D_ADDR = 12'h020; D_BE = 4'b0011; D_WDATA = 32'hDEADBEEF;
        @(negedge CLK);
        chk("st_d_gnt", 32'(D_GNT), 32'd1);
        chk("st_m_wen", 32'(M_WEN), 32'd0);
        chk("st_m_be", 32'(M_BE), 32'h3);
        chk("st_m_dout", M_DOUT, 32'hDEADBEEF);
        next();
        D_WE = 0;
        @(negedge CLK);
        chk("ld_m_wen", 32'(M_WEN), 32'd1);
        chk("ld_m_be", 32'(M_BE), 32'hF);
        dq.push_back(32'h120);
        next();
        D_REQ = 0;
        next();
        @(negedge CLK);
        chk("ld_d_valid_c3", 32'(D_VALID), 32'd1);
        repeat (3) next();

        I_REQ = 1; I_ADDR = 12'h030;
        @(negedge CLK);
        chk("fl_i_gnt_c0", 32'(I_GNT), 32'd1);
        next();
        I_ADDR = 12'h031;
        @(negedge CLK);
        chk("fl_i_gnt_c1", 32'(I_GNT), 32'd1);
        next();
        I_ADDR = 12'h032; FLUSH = 1; D_REQ = 1; D_WE = 0; D_ADDR = 12'h040;
        @(negedge CLK);
        chk("fl_i_gnt_c2", 32'(I_GNT), 32'd0);
        chk("fl_d_gnt_c2", 32'(D_GNT), 32'd1);
        chk("fl_i_valid_c2", 32'(I_VALID), 32'd0);
        dq.push_back(32'h140);
        next();
        FLUSH = 0; I_REQ = 0; D_REQ = 0;
        @(negedge CLK);
        chk("fl_i_valid_c3", 32'(I_VALID), 32'd0);
        next();
        @(negedge CLK);
        chk("fl_d_valid_c4", 32'(D_VALID), 32'd1);
        repeat (3) next();

        D_REQ = 1; D_WE = 0; D_ADDR = 12'h050;
        @(negedge CLK);
        chk("rmf_d_gnt", 32'(D_GNT), 32'd1);
        next();
        D_REQ = 0; RST = 1;
        @(negedge CLK);
        chk("rmf_d_valid_c1", 32'(D_VALID), 32'd0);
        next();
        RST = 0;
        for (int c = 2; c < 5; c++) begin
            @(negedge CLK);
            chk("rmf_d_valid", 32'(D_VALID), 32'd0);
            next();
        end

        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
